// File: rtl/breakout_pixel_pipe_if.sv
// Scan-side bundle for the Breakout pixel pipe:
// coordinates in, registered colour out.
interface breakout_pixel_pipe_if;
    logic       pix_valid;
    logic       frame_start;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;
    logic       rgb_valid;

    modport master (
        output pix_valid, frame_start, DrawX, DrawY,
        input  Red, Green, Blue, rgb_valid
    );

    modport slave (
        input  pix_valid, frame_start, DrawX, DrawY,
        output Red, Green, Blue, rgb_valid
    );
endinterface

// File: rtl/breakout_pixel_pipe.sv
// Breakout pixel colour pipe: bricks, ball, paddle, score text,
// life markers and lost-life border flash; two-stage registered RGB.
module breakout_font_rom (
    input  logic [10:0] addr,
    output logic [7:0]  data
);
    logic [127:0] g;

    // One 8x16 glyph per code, row 0 in the top byte.
    always_comb begin
        g = '0;
        case (addr[10:4])
            7'h30: g = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            7'h31: g = 128'h00001838781818181818187E00000000;
            7'h32: g = 128'h00007CC6060C183060C0C6FE00000000;
            7'h33: g = 128'h00007CC606063C060606C67C00000000;
            7'h34: g = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            7'h35: g = 128'h0000FEC0C0C0FC060606C67C00000000;
            7'h36: g = 128'h00003860C0C0FCC6C6C6C67C00000000;
            7'h37: g = 128'h0000FEC606060C183030303000000000;
            7'h38: g = 128'h00007CC6C6C67CC6C6C6C67C00000000;
            7'h39: g = 128'h00007CC6C6C67E0606060C7800000000;
            7'h3A: g = 128'h00000000181800000018180000000000;
            7'h53: g = 128'h00007CC6C660380C06C6C67C00000000;
            7'h63: g = 128'h00000000007CC6C0C0C0C67C00000000;
            7'h65: g = 128'h00000000007CC6FEC0C0C67C00000000;
            7'h6F: g = 128'h00000000007CC6C6C6C6C67C00000000;
            7'h72: g = 128'h0000000000DC7666606060F000000000;
            default: g = '0;
        endcase
    end

    assign data = g[{~addr[3:0], 3'b000} +: 8];
endmodule

module breakout_pixel_pipe #(
    parameter int  COLS      = 8,
    parameter int  ROWS      = 4,
    parameter int  BLK_W     = 80,
    parameter int  BLK_H     = 20,
    parameter int  TOP_Y     = 10,
    parameter int  MAX_LIVES = 3,
    parameter int  SCORE_DIG = 4,
    parameter int  POINTS    = 1,
    parameter int  FLASH_FRM = 30,
    localparam int LW        = $clog2(MAX_LIVES + 1),
    localparam int NB        = ROWS * COLS,
    localparam int SW        = 4 * SCORE_DIG
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    breakout_pixel_pipe_if.slave pix,
    input  logic [9:0]           BallX,
    input  logic [9:0]           BallY,
    input  logic [9:0]           Ball_size,
    input  logic [9:0]           BarX,
    input  logic [9:0]           BarY,
    input  logic [9:0]           Bar_SizeX,
    input  logic [9:0]           Bar_SizeY,
    input  logic [9:0]           Block_SizeX,
    input  logic [9:0]           Block_SizeY,
    input  logic [NB-1:0]        Block_Array,
    input  logic [LW-1:0]        lives,
    input  logic                 block_hit,
    input  logic                 score_clear,
    output logic [SW-1:0]        score_bcd
);

    localparam int FW  = $clog2(FLASH_FRM + 1);
    localparam int SCW = 8 * (6 + SCORE_DIG);

    typedef struct packed {
        logic        vld;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        ball;
        logic        pad;
        logic        brick;
        logic [1:0]  pal;
        logic        life;
        logic        flash;
        logic [10:0] faddr;
    } s1_t;

    s1_t           s1_d;
    s1_t           s1_q;
    logic [23:0]   rgb_d;
    logic [23:0]   rgb_q;
    logic          vld_q;
    logic [7:0]    frow;

    logic [SW-1:0] score_q;
    logic [SW-1:0] score_nx;
    logic [SW-1:0] shadow_q;
    logic          carry;
    logic [4:0]    dsum;
    logic [LW-1:0] prev_lives;
    logic [FW-1:0] flash_cnt;

    logic [9:0]    dx;
    logic [9:0]    dy;
    logic [19:0]   dx2;
    logic [19:0]   dy2;
    logic [19:0]   r2;
    logic          brk;
    logic [1:0]    pal;
    logic          life;
    logic [6:0]    ci;
    logic [6:0]    ch;
    logic          brd;
    logic          scr;
    logic          fbit;
    logic [23:0]   pal_rgb;

    // Low edge clamps at zero so objects near the left/top edge still hit.
    function automatic logic in_span(
        input logic [9:0] d,
        input logic [9:0] c,
        input logic [9:0] h
    );
        logic [10:0] lo;
        logic [10:0] hi;
        lo = (c >= h) ? {1'b0, c - h} : 11'd0;
        hi = {1'b0, c} + {1'b0, h};
        return ({1'b0, d} >= lo) && ({1'b0, d} <= hi);
    endfunction

    always_comb begin
        dx  = (pix.DrawX >= BallX) ? pix.DrawX - BallX : BallX - pix.DrawX;
        dy  = (pix.DrawY >= BallY) ? pix.DrawY - BallY : BallY - pix.DrawY;
        dx2 = 20'(dx) * 20'(dx);
        dy2 = 20'(dy) * 20'(dy);
        r2  = 20'(Ball_size) * 20'(Ball_size);
    end

    // Scan from the top index down so the lowest present brick wins.
    always_comb begin
        brk = 1'b0;
        pal = 2'd0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (Block_Array[i]
                && in_span(pix.DrawX,
                           10'((i % COLS) * BLK_W + BLK_W / 2),
                           Block_SizeX)
                && in_span(pix.DrawY,
                           10'(TOP_Y + (i / COLS) * BLK_H),
                           Block_SizeY)) begin
                brk = 1'b1;
                pal = 2'(((i / COLS) + (i % COLS)) % 3);
            end
        end
    end

    always_comb begin
        life = 1'b0;
        for (int k = 0; k < MAX_LIVES; k++) begin
            if (int'(lives) > k
                && int'(pix.DrawX) >= 624 - 30 * k
                && int'(pix.DrawX) <= 638 - 30 * k
                && pix.DrawY >= 10'd465
                && pix.DrawY <= 10'd479)
                life = 1'b1;
        end
    end

    always_comb begin
        ci = pix.DrawX[9:3];
        unique case (ci)
            7'd0:    ch = 7'h53;
            7'd1:    ch = 7'h63;
            7'd2:    ch = 7'h6F;
            7'd3:    ch = 7'h72;
            7'd4:    ch = 7'h65;
            7'd5:    ch = 7'h3A;
            default: ch = 7'h20;
        endcase
        for (int d = 0; d < SCORE_DIG; d++) begin
            if (ci == 7'(6 + SCORE_DIG - 1 - d))
                ch = {3'h3, shadow_q[4*d +: 4]};
        end
    end

    always_comb begin
        s1_d       = '0;
        s1_d.vld   = pix.pix_valid;
        s1_d.x     = pix.DrawX;
        s1_d.y     = pix.DrawY;
        s1_d.ball  = ({1'b0, dx2} + {1'b0, dy2}) <= {1'b0, r2};
        s1_d.pad   = in_span(pix.DrawX, BarX, Bar_SizeX)
                     && in_span(pix.DrawY, BarY, Bar_SizeY);
        s1_d.brick = brk;
        s1_d.pal   = pal;
        s1_d.life  = life;
        s1_d.flash = (flash_cnt != '0) && flash_cnt[2];
        s1_d.faddr = {ch, pix.DrawY[3:0]};
    end

    breakout_font_rom u_font (
        .addr (s1_q.faddr),
        .data (frow)
    );

    always_comb begin
        brd  = s1_q.x < 10'd4 || s1_q.x > 10'd635 || s1_q.y < 10'd4;
        scr  = s1_q.y >= 10'd464 && s1_q.y <= 10'd479
               && s1_q.x < 10'(SCW);
        fbit = frow[3'd7 - s1_q.x[2:0]];
        unique case (s1_q.pal)
            2'd0:    pal_rgb = 24'h10A201;
            2'd1:    pal_rgb = 24'h801F80;
            default: pal_rgb = 24'h80FF55;
        endcase
    end

    always_comb begin
        rgb_d = 24'h000000;
        if (s1_q.vld) begin
            priority case (1'b1)
                brd && s1_q.flash: rgb_d = 24'hFF0000;
                s1_q.life:         rgb_d = 24'hE0E722;
                scr:               rgb_d = fbit ? 24'hFFFFFF : 24'h000000;
                s1_q.brick:        rgb_d = pal_rgb;
                s1_q.pad:          rgb_d = 24'h808080;
                s1_q.ball:         rgb_d = 24'hFF5500;
                default:           rgb_d = 24'h0000FF;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_q  <= '0;
            rgb_q <= '0;
            vld_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            rgb_q <= rgb_d;
            vld_q <= s1_q.vld;
        end
    end

    assign pix.Red       = rgb_q[23:16];
    assign pix.Green     = rgb_q[15:8];
    assign pix.Blue      = rgb_q[7:0];
    assign pix.rgb_valid = vld_q;

    // BCD ripple add; a carry out of the top digit pins the score at all 9s.
    always_comb begin
        carry    = 1'b0;
        dsum     = 5'd0;
        score_nx = score_q;
        for (int i = 0; i < SCORE_DIG; i++) begin
            dsum = {1'b0, score_q[4*i +: 4]} + 5'(carry)
                   + ((i == 0) ? 5'(POINTS) : 5'd0);
            if (dsum > 5'd9) begin
                score_nx[4*i +: 4] = 4'(dsum - 5'd10);
                carry              = 1'b1;
            end else begin
                score_nx[4*i +: 4] = dsum[3:0];
                carry              = 1'b0;
            end
        end
        if (carry)
            score_nx = {SCORE_DIG{4'h9}};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_q  <= '0;
            shadow_q <= '0;
        end else begin
            if (score_clear)
                score_q <= '0;
            else if (block_hit)
                score_q <= score_nx;
            if (pix.frame_start)
                shadow_q <= score_q;
        end
    end

    assign score_bcd = score_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_lives <= '0;
            flash_cnt  <= '0;
        end else begin
            prev_lives <= lives;
            if (lives < prev_lives)
                flash_cnt <= FW'(FLASH_FRM);
            else if (pix.frame_start && flash_cnt != '0)
                flash_cnt <= flash_cnt - 1'b1;
        end
    end

endmodule
